// File: rtl/matrix_result_tx_if.sv
// Start/result handshake and UART line status shared by matrix_result_tx and its user.
// With RESULT_TX_CHECKSUM_EN the byte index widens to reach the 65th (checksum) character.
interface matrix_result_tx_if #(
    parameter int N_WORDS    = 16,
    parameter int WORD_WIDTH = 32,
`ifdef RESULT_TX_CHECKSUM_EN
    parameter int IDX_W      = 7
`else
    parameter int IDX_W      = 6
`endif
);
    logic                          start;
    logic [N_WORDS*WORD_WIDTH-1:0] result;
    logic                          tx;
    logic                          busy;
    logic                          done;
    logic [IDX_W-1:0]              byte_idx;

    modport master (output start, output result, input tx, input busy, input done, input byte_idx);
    modport slave  (input start, input result, output tx, output busy, output done, output byte_idx);
endinterface

// File: rtl/matrix_result_tx.sv
// Captures the 4x4 result matrix on start and sends it big-endian, row-major as UART characters.
// Optional macro RESULT_TX_CHECKSUM_EN appends an XOR-of-all-bytes checksum character.
module matrix_result_tx #(
    parameter int OVERSAMPLE  = 13,
    parameter int N_DATA_BITS = 8,
    parameter int STOP_BITS   = 1,
    parameter int N_WORDS     = 16,
    parameter int WORD_WIDTH  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    matrix_result_tx_if.slave tx_if
);
    localparam int TOTAL_W = N_WORDS * WORD_WIDTH;
    localparam int N_CHARS = TOTAL_W / N_DATA_BITS;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int LAST_IDX = N_CHARS;
`else
    localparam int LAST_IDX = N_CHARS - 1;
`endif
    localparam int IDX_W  = $clog2(LAST_IDX + 1);
    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

    // state | meaning
    // IDLE  | line high, waiting for start
    // START | start bit (low)
    // DATA  | N_DATA_BITS data bits, LSB first
    // STOP  | STOP_BITS stop bits (high)
    // NEXT  | single clock to advance to the next character
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    state_t                   state_q;
    logic [TICK_W-1:0]        tick_q;
    logic [BIT_W-1:0]         bit_q;
    logic                     stop_q;
    logic [IDX_W-1:0]         k_q;
    logic [TOTAL_W-1:0]       shadow_q;
    logic [N_DATA_BITS-1:0]   shreg_q;
    logic                     tx_q;
    logic                     busy_q;
    logic                     done_q;
`ifdef RESULT_TX_CHECKSUM_EN
    logic [N_DATA_BITS-1:0]   csum_q;
`endif

    logic                     bit_end;
    logic [IDX_W-1:0]         k_next_d;
    logic [N_DATA_BITS-1:0]   char_next_d;

    // Character 0 is the most significant slice: C[0][0] top byte.
    function automatic logic [N_DATA_BITS-1:0] char_at(input logic [TOTAL_W-1:0] src, input int idx);
        if (idx >= N_CHARS) return '0;
        return src[(N_CHARS-1-idx)*N_DATA_BITS +: N_DATA_BITS];
    endfunction

    assign bit_end = i_en && (tick_q == TICK_W'(OVERSAMPLE - 1));

    always_comb begin
        k_next_d    = k_q + 1'b1;
        char_next_d = char_at(shadow_q, int'(k_next_d));
`ifdef RESULT_TX_CHECKSUM_EN
        if (int'(k_q) == N_CHARS - 1) char_next_d = csum_q;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            k_q      <= '0;
            shadow_q <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (i_en && (state_q == START || state_q == DATA || state_q == STOP))
                tick_q <= bit_end ? '0 : tick_q + 1'b1;

            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_if.start) begin
                        shadow_q <= tx_if.result;
                        shreg_q  <= char_at(tx_if.result, 0);
                        k_q      <= '0;
                        tick_q   <= '0;
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
`ifdef RESULT_TX_CHECKSUM_EN
                        csum_q   <= char_at(tx_if.result, 0);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == BIT_W'(N_DATA_BITS - 1)) begin
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_q == 1'(STOP_BITS - 1)) begin
                            if (int'(k_q) == LAST_IDX) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= NEXT;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    k_q     <= k_next_d;
                    shreg_q <= char_next_d;
                    tick_q  <= '0;
                    stop_q  <= 1'b0;
                    tx_q    <= 1'b0;
                    state_q <= START;
`ifdef RESULT_TX_CHECKSUM_EN
                    if (int'(k_next_d) < N_CHARS) csum_q <= csum_q ^ char_next_d;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_if.tx       = tx_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.done     = done_q;
    assign tx_if.byte_idx = k_q;

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: UART line monitor decodes characters into a queue that
// is checked against bytes predicted from the captured matrix.
`timescale 1ns/1ps
module tb_matrix_result_tx;
    localparam int OS        = 2;
    localparam int STOP_BITS = 1;
    localparam int N_CHARS   = 64;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int N_FRAME = 65;
    localparam int IDX_W   = 7;
`else
    localparam int N_FRAME = 64;
    localparam int IDX_W   = 6;
`endif
    localparam int LAST = N_FRAME - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic en_run = 1'b1;

    int errors = 0;
    int checks = 0;

    matrix_result_tx_if #(.N_WORDS(16), .WORD_WIDTH(32), .IDX_W(IDX_W)) bus ();

    matrix_result_tx #(.OVERSAMPLE(OS), .N_DATA_BITS(8), .STOP_BITS(STOP_BITS),
                       .N_WORDS(16), .WORD_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .tx_if(bus)
    );

    always #5 clk = ~clk;

    // i_en high on every other rising edge while en_run is set.
    initial forever begin
        @(posedge clk);
        #2;
        en = en_run ? ~en : 1'b0;
    end

    // Line monitor: counts i_en pulses per bit, samples each bit as it begins.
    int m_state = 0, m_cnt = 0, m_bit = 0, m_nstop = 0;
    logic m_level = 1'b1, m_prev = 1'b1;
    logic [7:0] m_byte = '0;
    int glitch = 0, framing = 0, idx_err = 0, m_bits = 0, m_exp_idx = 0;
    int done_cnt = 0, cyc = 0, last_stop_cyc = -1, done_cyc = -2;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (rst) m_state = 0;
        else if (m_state == 0) begin
            if (m_prev === 1'b1 && bus.tx === 1'b0) begin
                m_state = 1; m_cnt = 0; m_level = 1'b0;
                if (bus.byte_idx !== IDX_W'(m_exp_idx)) idx_err++;
                m_exp_idx++;
            end
        end else begin
            if (en) m_cnt++;
            if (m_cnt == OS) begin
                m_cnt = 0;
                m_bits++;
                if (m_state == 1) begin
                    m_byte[0] = bus.tx; m_bit = 1; m_state = 2; m_level = bus.tx;
                end else if (m_state == 2) begin
                    if (m_bit < 8) begin
                        m_byte[m_bit] = bus.tx; m_bit++; m_level = bus.tx;
                    end else begin
                        if (bus.tx !== 1'b1) framing++;
                        m_level = 1'b1; m_nstop = 0; m_state = 3;
                    end
                end else begin
                    m_nstop++;
                    if (m_nstop == STOP_BITS) begin
                        rx_q.push_back(m_byte); last_stop_cyc = cyc; m_state = 0;
                    end
                end
            end else if (bus.tx !== m_level) glitch++;
        end
        m_prev = bus.tx;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    function automatic logic [7:0] byte_of(input logic [511:0] res, input int k);
        logic [31:0] w;
        w = res[(15 - k / 4) * 32 +: 32];
        return w[(3 - k % 4) * 8 +: 8];
    endfunction

    function automatic logic [511:0] rand_matrix();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w * 32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic start_frame(input logic [511:0] res);
        logic [7:0] x, b;
        x = '0;
        for (int k = 0; k < N_CHARS; k++) begin
            b = byte_of(res, k);
            exp_q.push_back(b);
            x ^= b;
        end
`ifdef RESULT_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        m_exp_idx = 0; m_bits = 0; done_cnt = 0; glitch = 0; framing = 0; idx_err = 0;
        bus.result = res;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (n < budget && done_cnt == 0) begin tick(); n++; end
        ok = (done_cnt != 0);
    endtask

    task automatic test_reset();
        int bad_tx, bad_busy, bad_done, bad_idx;
        bad_tx = 0; bad_busy = 0; bad_done = 0; bad_idx = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (200) begin
            tick();
            if (bus.tx !== 1'b1) bad_tx++;
            if (bus.busy !== 1'b0) bad_busy++;
            if (bus.done !== 1'b0) bad_done++;
            if (bus.byte_idx !== '0) bad_idx++;
        end
        checks += 4;
        if (bad_tx != 0) begin errors++; $display("FAIL reset_tx: %0d bad cycles, want 0", bad_tx); end
        if (bad_busy != 0) begin errors++; $display("FAIL reset_busy: %0d bad cycles, want 0", bad_busy); end
        if (bad_done != 0) begin errors++; $display("FAIL reset_done: %0d bad cycles, want 0", bad_done); end
        if (bad_idx != 0) begin errors++; $display("FAIL reset_idx: %0d bad cycles, want 0", bad_idx); end
    endtask

    task automatic test_single_frame();
        logic [511:0] res;
        logic [7:0] e, r;
        bit ok;
        res = '0;
        res[511:480] = 32'h12345678;
        start_frame(res);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        wait_done(4000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done_timeout: got none want 1 pulse"); end
        checks++;
        if (done_cyc != last_stop_cyc) begin errors++; $display("FAIL single_done_align: got cyc %0d want %0d", done_cyc, last_stop_cyc); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
        repeat (20) tick();
        checks += 5;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
        if (m_bits != N_FRAME * 10) begin errors++; $display("FAIL single_bit_periods: got %0d want %0d", m_bits, N_FRAME * 10); end
        if (glitch != 0) begin errors++; $display("FAIL single_glitch: got %0d want 0", glitch); end
        if (framing != 0) begin errors++; $display("FAIL single_framing: got %0d want 0", framing); end
        if (idx_err != 0) begin errors++; $display("FAIL single_idx: got %0d want 0", idx_err); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin errors++; $display("FAIL single_byte%0d: got %02h want %02h", i, r, e); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_bit_level();
        logic [511:0] res;
        logic smp[60];
        int rl[$];
        logic rv[$];
        int exp_len[8];
        logic cur;
        int len;
        bit ok;
        exp_len = '{0, 4, 4, 4, 8, 4, 4, 9};
        res = '0;
        res[511:480] = 32'hA5000000;
        start_frame(res);
        for (int i = 0; i < 60; i++) begin @(posedge clk); #1; smp[i] = bus.tx; end
        cur = smp[0]; len = 1;
        for (int i = 1; i < 60; i++) begin
            if (smp[i] === cur) len++;
            else begin rv.push_back(cur); rl.push_back(len); cur = smp[i]; len = 1; end
        end
        checks++;
        if (rl.size() < 8) begin
            errors++; $display("FAIL bit_runs: got %0d runs want >= 8", rl.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rv[i] !== 1'(i % 2)) begin errors++; $display("FAIL bit_val%0d: got %b want %0d", i, rv[i], i % 2); end
                if (i > 0) begin
                    checks++;
                    if (rl[i] != exp_len[i]) begin errors++; $display("FAIL bit_len%0d: got %0d want %0d", i, rl[i], exp_len[i]); end
                end
            end
        end
        wait_done(4000, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL bit_done_timeout: got none want 1 pulse"); end
        if (rx_q.size() == 0 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL bit_byte0: got %0d bytes want first A5", rx_q.size()); end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_busy_reject();
        logic [511:0] res;
        logic [7:0] e, r;
        int n;
        bit ok;
        res = rand_matrix();
        start_frame(res);
        n = 0;
        while (n < 2000 && bus.byte_idx != IDX_W'(10)) begin tick(); n++; end
        checks++;
        if (bus.byte_idx != IDX_W'(10)) begin errors++; $display("FAIL busy_reach10: got %0d want 10", bus.byte_idx); end
        bus.result = ~res;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(4000, ok);
        repeat (20) tick();
        checks += 4;
        if (!ok) begin errors++; $display("FAIL busy_done_timeout: got none want 1 pulse"); end
        if (done_cnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
        if (idx_err != 0) begin errors++; $display("FAIL busy_idx: got %0d want 0", idx_err); end
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin errors++; $display("FAIL busy_byte%0d: got %02h want %02h", i, r, e); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_freeze();
        logic [511:0] res;
        logic [7:0] e, r;
        logic tx0;
        logic [IDX_W-1:0] idx0;
        int n, bad;
        bit ok;
        res = rand_matrix();
        start_frame(res);
        n = 0;
        while (n < 2000 && bus.byte_idx != IDX_W'(5)) begin tick(); n++; end
        repeat (7) tick();
        en_run = 1'b0;
        repeat (2) tick();
        tx0 = bus.tx; idx0 = bus.byte_idx; bad = 0;
        repeat (50) begin
            tick();
            if (bus.tx !== tx0 || bus.byte_idx !== idx0 || bus.busy !== 1'b1) bad++;
        end
        en_run = 1'b1;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL freeze_stable: got %0d changed cycles want 0", bad); end
        wait_done(4000, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL freeze_done_timeout: got none want 1 pulse"); end
        if (glitch != 0) begin errors++; $display("FAIL freeze_glitch: got %0d want 0", glitch); end
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL freeze_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin errors++; $display("FAIL freeze_byte%0d: got %02h want %02h", i, r, e); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [511:0] res;
        logic [7:0] e, r;
        int n;
        bit ok;
        res = rand_matrix();
        start_frame(res);
        n = 0;
        while (n < 2000 && !(bus.byte_idx == IDX_W'(20) && m_state == 2)) begin tick(); n++; end
        checks++;
        if (!(bus.byte_idx == IDX_W'(20) && m_state == 2)) begin errors++; $display("FAIL rstmid_reach: got idx %0d want 20 in data", bus.byte_idx); end
        rst = 1'b1;
        tick();
        checks += 3;
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus.tx); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        if (bus.byte_idx !== '0) begin errors++; $display("FAIL rstmid_idx: got %0d want 0", bus.byte_idx); end
        rst = 1'b0;
        repeat (100) tick();
        checks += 2;
        if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL rstmid_idle_tx: got %b want 1", bus.tx); end
        exp_q.delete(); rx_q.delete();
        res = rand_matrix();
        start_frame(res);
        wait_done(4000, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL rstmid_done_timeout: got none want 1 pulse"); end
        if (m_bits != N_FRAME * 10) begin errors++; $display("FAIL rstmid_bit_periods: got %0d want %0d", m_bits, N_FRAME * 10); end
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin errors++; $display("FAIL rstmid_byte%0d: got %02h want %02h", i, r, e); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_start_on_done();
        logic [511:0] res;
        int n;
        res = rand_matrix();
        start_frame(res);
        n = 0;
        while (n < 4000 && !(bus.byte_idx == IDX_W'(LAST) && m_state == 3 && m_cnt == OS - 1 && en == 1'b1)) begin
            tick(); n++;
        end
        bus.result = ~res;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks += 2;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL sod_done: got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL sod_busy: got %b want 0", bus.busy); end
        repeat (50) tick();
        checks += 3;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL sod_no_restart: got busy %b want 0", bus.busy); end
        if (bus.tx !== 1'b1) begin errors++; $display("FAIL sod_tx_idle: got %b want 1", bus.tx); end
        if (done_cnt != 1) begin errors++; $display("FAIL sod_done_count: got %0d want 1", done_cnt); end
        exp_q.delete(); rx_q.delete();
    endtask

`ifdef RESULT_TX_CHECKSUM_EN
    task automatic test_checksum();
        logic [511:0] res;
        logic [7:0] e, r, want;
        bit ok;
        for (int f = 0; f < 2; f++) begin
            res = '0;
            if (f == 0) begin
                for (int w = 0; w < 16; w++) res[(15 - w) * 32 +: 32] = 32'h01010101 * w;
                want = 8'h00;
            end else begin
                res[511:480] = 32'h000000FF;
                want = 8'hFF;
            end
            start_frame(res);
            wait_done(4000, ok);
            checks += 4;
            if (!ok) begin errors++; $display("FAIL csum%0d_done_timeout: got none want 1 pulse", f); end
            if (idx_err != 0) begin errors++; $display("FAIL csum%0d_idx: got %0d want 0", f, idx_err); end
            if (rx_q.size() != 65) begin errors++; $display("FAIL csum%0d_count: got %0d want 65", f, rx_q.size()); end
            if (rx_q.size() == 0 || rx_q[rx_q.size() - 1] !== want) begin
                errors++; $display("FAIL csum%0d_last: got %0d bytes want last %02h", f, rx_q.size(), want);
            end
            for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
                e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
                if (r !== e) begin errors++; $display("FAIL csum%0d_byte%0d: got %02h want %02h", f, i, r, e); end
            end
            exp_q.delete(); rx_q.delete();
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.result = '0;
        test_reset();
        test_single_frame();
        test_bit_level();
        test_busy_reject();
        test_freeze();
        test_reset_mid();
        test_start_on_done();
`ifdef RESULT_TX_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
